// File: rtl/cpu_types_pkg.sv
// Shared CPU types: machine word, instruction-cache address/frame layouts and FSM states.
// Default geometry is ICACHE_ROWS frames of one word each.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    localparam int ICACHE_ROWS  = 16;
    localparam int ICACHE_IDX_W = $clog2(ICACHE_ROWS);
    localparam int ICACHE_TAG_W = 30 - ICACHE_IDX_W;

    typedef struct packed {
        logic [ICACHE_TAG_W-1:0] tag;
        logic [ICACHE_IDX_W-1:0] idx;
        logic [1:0]              bytoff;
    } icachef_t;

    typedef struct packed {
        logic                    valid;
        logic [ICACHE_TAG_W-1:0] tag;
        word_t                   data;
    } icache_frame_t;

    typedef enum logic {
        IC_IDLE  = 1'b0,
        IC_FETCH = 1'b1
    } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Instruction-cache bus: datapath fetch port plus memory-controller instruction port.
// The slave modport is the cache's view; master is the surrounding system's view.
interface icache_if;
    import cpu_types_pkg::*;

    logic  imemREN;
    word_t imemaddr;
    logic  ihit;
    word_t imemload;
    logic  iREN;
    word_t iaddr;
    logic  iwait;
    word_t iload;

    modport slave (
        input  imemREN, imemaddr, iwait, iload,
        output ihit, imemload, iREN, iaddr
    );

    modport master (
        output imemREN, imemaddr, iwait, iload,
        input  ihit, imemload, iREN, iaddr
    );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-frame instruction cache with combinational hits and a blocking fill.
// Optional hit/miss counters are built when ICACHE_STATS_EN is defined.
module icache
    import cpu_types_pkg::*;
#(
    parameter int ROWS = ICACHE_ROWS
) (
    input  logic    CLK,
    input  logic    nRST,
    icache_if.slave bus
`ifdef ICACHE_STATS_EN
    ,
    output word_t   hit_count,
    output word_t   miss_count
`endif
);

    localparam int IDX_W = $clog2(ROWS);
    localparam int TAG_W = 30 - IDX_W;

    typedef struct packed {
        logic [TAG_W-1:0] tag;
        logic [IDX_W-1:0] idx;
        logic [1:0]       bytoff;
    } addr_t;

    typedef struct packed {
        logic             valid;
        logic [TAG_W-1:0] tag;
        word_t            data;
    } frame_t;

    icache_state_t r_state;
    icache_state_t w_state_next;
    frame_t        r_frames [ROWS];
    word_t         r_miss_addr;
    addr_t         w_req;
    addr_t         w_miss;
    logic          w_hit;
    logic          w_miss_start;
    logic          w_fill;

    assign w_req  = addr_t'(bus.imemaddr);
    assign w_miss = addr_t'(r_miss_addr);

    assign w_hit = bus.imemREN
                && r_frames[w_req.idx].valid
                && (r_frames[w_req.idx].tag == w_req.tag);

    assign w_miss_start = (r_state == IC_IDLE) && bus.imemREN && !w_hit;
    assign w_fill       = (r_state == IC_FETCH) && !bus.iwait;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state <= IC_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IC_IDLE:  if (w_miss_start) w_state_next = IC_FETCH;
            IC_FETCH: if (!bus.iwait)   w_state_next = IC_IDLE;
            default:  w_state_next = IC_IDLE;
        endcase
    end

    always_comb begin
        bus.ihit     = 1'b0;
        bus.imemload = '0;
        bus.iREN     = 1'b0;
        bus.iaddr    = '0;
        case (r_state)
            IC_IDLE: begin
                if (w_hit) begin
                    bus.ihit     = 1'b1;
                    bus.imemload = r_frames[w_req.idx].data;
                end
            end
            IC_FETCH: begin
                bus.iREN  = 1'b1;
                bus.iaddr = r_miss_addr;
            end
            default: ;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_miss_addr <= '0;
        end else if (w_miss_start) begin
            r_miss_addr <= {bus.imemaddr[31:2], 2'b00};
        end
    end

    // Frames need a real reset because valid must clear; the fill targets the latched miss index.
    for (genvar gi = 0; gi < ROWS; gi++) begin : g_frame
        always_ff @(posedge CLK or negedge nRST) begin
            if (!nRST) begin
                r_frames[gi] <= '0;
            end else if (w_fill && (w_miss.idx == IDX_W'(gi))) begin
                r_frames[gi] <= '{valid: 1'b1, tag: w_miss.tag, data: bus.iload};
            end
        end
    end

`ifdef ICACHE_STATS_EN
    word_t r_hit_count;
    word_t r_miss_count;

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_hit_count  <= '0;
            r_miss_count <= '0;
        end else begin
            if (bus.ihit)     r_hit_count  <= r_hit_count + 32'd1;
            if (w_miss_start) r_miss_count <= r_miss_count + 32'd1;
        end
    end

    assign hit_count  = r_hit_count;
    assign miss_count = r_miss_count;
`endif

endmodule

// File: doc/icache.md
# icache

Direct-mapped, one-word-per-block instruction cache sitting between the datapath's instruction fetch port and the memory controller's instruction port. It serves `imemREN`/`imemaddr` requests from the datapath, answers hits in the same cycle and runs a fill from memory on a miss. Its datapath-side ports connect to the datapath's instruction fetch port, and its memory-side ports connect to the memory controller's instruction port.

## Interface
Parameters:
- `ROWS`, 16: number of frames; power of two, at least 2. `IDX_W = $clog2(ROWS)`, `TAG_W = 30 - IDX_W`.

Ports (one clock; reset is asynchronous and active-low):
- `CLK`  in  1  system clock
- `nRST`  in  1  asynchronous active-low reset
- `imemREN`  in  1  datapath fetch request
- `imemaddr`  in  32  fetch byte address; bits [1:0] ignored
- `ihit`  out  1  requested word is valid on `imemload` this cycle
- `imemload`  out  32  instruction word
- `iREN`  out  1  read request to the memory controller
- `iaddr`  out  32  memory read address, word-aligned
- `iwait`  in  1  memory busy; low means `iload` is valid
- `iload`  in  32  memory read data

## Operation
- Address split: tag = `imemaddr[31:IDX_W+2]`, index = `imemaddr[IDX_W+1:2]`.
- Each frame holds `valid`, `tag` and `data`. All `valid` bits are cleared on reset.
- The FSM has two states, `IDLE` and `FETCH`.
- **IDLE:**
  - Hit = `imemREN` and the indexed frame's `valid` is set and its tag matches.
  - On a hit: `ihit=1` and `imemload` = frame data, both combinationally.
  - On a miss with `imemREN=1`: latch `imemaddr` word-aligned into `miss_addr` and go to `FETCH`.
  - With `imemREN=0`: `ihit=0` and the state does not change.
- **FETCH:**
  - Drive `iREN=1` and `iaddr=miss_addr`.
  - While `iwait=1`, stay in `FETCH`.
  - When `iwait=0`, write frame[index(`miss_addr`)] with `valid=1`, the tag of `miss_addr` and `iload`, then go to `IDLE`.
  - `ihit` stays 0 throughout `FETCH`.
- The fill always completes, even if `imemREN` drops or `imemaddr` changes during `FETCH`. The fetch is then re-evaluated in `IDLE`.
- Eviction: a fill unconditionally overwrites the indexed frame. There is no write-back because instruction memory is read-only.
- Outside `FETCH`: `iREN=0` and `iaddr=0`.
- When `ihit=0`, `imemload=0`.

## Timing
- Reset values: state `IDLE`, every frame `valid=0`, `miss_addr=0`, `ihit=0`, `imemload=0`, `iREN=0`, `iaddr=0`.
- Hit latency: 0 cycles, combinational from `imemaddr`.
- Miss penalty: 1 cycle to enter `FETCH`, plus the number of cycles `iwait` is high, plus 1 fill cycle. The hit follows in the next `IDLE` cycle.
- The frame array and the state register update on `posedge CLK`.
- Reset asserted mid-`FETCH` aborts the fill immediately. `iREN` drops asynchronously and no frame is written.

## Configuration
- `ICACHE_STATS_EN` defined: adds outputs `hit_count` (out, 32) and `miss_count` (out, 32).
  - `hit_count` increments every cycle `ihit=1`.
  - `miss_count` increments on every `IDLE`→`FETCH` transition.
  - Both counters wrap modulo 2^32 and reset to 0.
- `ICACHE_STATS_EN` not defined: the counters and their ports are absent. Cache behaviour is unchanged.

## Structure
- `cpu_types_pkg`:
  - Reuse `word_t`.
  - Add `icachef_t` (packed fields: tag, index, byte offset), `icache_frame_t` (valid, tag, data) and the `ICACHE_ROWS` default constant.
- Single module with no sub-module. The frame array and the statistics counters are inline.

## Test plan
- Reset, then `imemREN=0` → `ihit=0`, `iREN=0`, `iaddr=0`, `imemload=0`.
- Cold miss: `imemaddr=0x00000000`, `iwait` high for 2 cycles then low with `iload=0x3C010004` → `iREN=1` for 3 cycles with `iaddr=0x0`. The next cycle gives `ihit=1` and `imemload=0x3C010004`.
- Re-fetch `0x00000000` → same-cycle `ihit=1` and `iREN` stays 0.
- Conflict (`ROWS=16`): fetch `0x40` after `0x0` → miss and fill. A following fetch of `0x0` misses again.
- Assert `nRST` low mid-`FETCH` → `iREN=0` at once. After release, `0x0` misses (the frame was invalidated).
- With `ICACHE_STATS_EN`: the sequence miss `0x0`, hit `0x0`, hit `0x0`, miss `0x40` → `miss_count=2`, `hit_count=4` (each post-fill hit cycle counts).
